// File: rtl/button_move_encoder.sv
// button_move_encoder
// Turns four debounced direction-button levels into a single stream of move
// commands: one on every press, plus typematic auto-repeat while the tracked
// button stays held. A one-entry valid/ready buffer sits on the output, and
// any event that arrives while that buffer is full is dropped and flagged in
// a sticky overflow bit.
module button_move_encoder #(
    parameter int CNT_W        = 24,
    parameter int REPEAT_DELAY = 12_500_000,
    parameter int REPEAT_RATE  = 2_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn,
    output logic       move_valid,
    output logic [1:0] move_dir,
    input  logic       move_ready,
    output logic       overflow,
    output logic       held
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] next_counter;
    logic [1:0]       active;
    logic [1:0]       next_active;
    logic [3:0]       btn_q;
    logic [3:0]       rise;
    logic             move_event;
    logic             next_event;

    // Lowest set index wins: up > down > left > right.
    function automatic logic [1:0] pri(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd3;
        if (v[2]) idx = 2'd2;
        if (v[1]) idx = 2'd1;
        if (v[0]) idx = 2'd0;
        return idx;
    endfunction

    assign rise = btn & ~btn_q;

    // State register: FSM state, hold counter, tracked button, edge history
    // and the registered event pulse that feeds the output buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            counter    <= '0;
            active     <= 2'd0;
            btn_q      <= 4'd0;
            move_event <= 1'b0;
        end else begin
            state      <= next_state;
            counter    <= next_counter;
            active     <= next_active;
            btn_q      <= btn;
            move_event <= next_event;
        end
    end

    // Next-state logic: a fresh press always wins, a release is handled
    // before the repeat timer so that letting go can never emit a command.
    always_comb begin
        next_state   = state;
        next_counter = counter;
        next_active  = active;
        next_event   = 1'b0;
        if (rise != 4'd0) begin
            next_active  = pri(rise);
            next_event   = 1'b1;
            next_counter = '0;
            next_state   = DELAY;
        end else begin
            case (state)
                IDLE: begin
                    next_counter = '0;
                end
                DELAY, REPEAT: begin
                    if (!btn[active]) begin
                        next_counter = '0;
                        if (btn != 4'd0) begin
                            next_active = pri(btn);
                            next_state  = DELAY;
                        end else begin
                            next_state  = IDLE;
                        end
                    end else if (state == DELAY) begin
                        if (counter == DELAY_LAST) begin
                            next_event   = 1'b1;
                            next_counter = '0;
                            next_state   = REPEAT;
                        end else begin
                            next_counter = counter + CNT_ONE;
                        end
                    end else begin
                        if (counter == RATE_LAST) begin
                            next_event   = 1'b1;
                            next_counter = '0;
                        end else begin
                            next_counter = counter + CNT_ONE;
                        end
                    end
                end
                default: begin
                    next_state   = IDLE;
                    next_counter = '0;
                end
            endcase
        end
    end

    // Output decode: held reports that some button is being tracked.
    always_comb begin
        held = 1'b0;
        if (state != IDLE) begin
            held = 1'b1;
        end
    end

    // One-entry output buffer: load on an event when it is empty or being
    // drained this cycle, otherwise drop the event and latch overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            move_valid <= 1'b0;
            move_dir   <= 2'd0;
            overflow   <= 1'b0;
        end else begin
            if (move_event) begin
                if (!move_valid || move_ready) begin
                    move_valid <= 1'b1;
                    move_dir   <= active;
                end else begin
                    overflow   <= 1'b1;
                end
            end else if (move_valid && move_ready) begin
                move_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_move_encoder.sv
// tb_button_move_encoder
// Directed bench for the move encoder with short repeat timings
// (first repeat after 8 cycles, then every 4). Single-cycle behaviour comes
// from a vector table; holds, re-presses and resets are walked by hand.
module tb_button_move_encoder;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       move_ready;
    logic       overflow;
    logic       held;

    int vectors_applied;
    int miscompares;

    typedef struct {
        logic [3:0] btn;
        logic       ready;
        logic       exp_valid;
        logic [1:0] exp_dir;
        logic       exp_ovf;
        logic       exp_held;
    } vec_t;

    localparam int NUM_VECS = 29;
    vec_t vecs [NUM_VECS];

    button_move_encoder #(
        .CNT_W        (24),
        .REPEAT_DELAY (8),
        .REPEAT_RATE  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (btn),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .move_ready (move_ready),
        .overflow   (overflow),
        .held       (held)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs on the falling edge, then sample just after the rising edge.
    task automatic applyStimulus(input logic [3:0] b, input logic r);
        @(negedge clk);
        btn        = b;
        move_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic ev, input logic [1:0] ed,
                               input logic eo, input logic eh);
        vectors_applied++;
        if (move_valid !== ev || move_dir !== ed || overflow !== eo || held !== eh) begin
            miscompares++;
            $display("[TB] FAIL %s[%0d]: got valid=%b dir=%0d ovf=%b held=%b, expected valid=%b dir=%0d ovf=%b held=%b",
                     name, idx, move_valid, move_dir, overflow, held, ev, ed, eo, eh);
        end
    endtask

    initial begin
        logic       ev;
        logic [1:0] ed;
        logic [3:0] b;

        vectors_applied = 0;
        miscompares     = 0;
        rst_n      = 1'b0;
        btn        = 4'd0;
        move_ready = 1'b1;

        // Pulse up for 3 cycles; then 0110 press and release of bit1.
        vecs[0]  = '{4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1};
        vecs[1]  = '{4'b0001, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1};
        vecs[2]  = '{4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1};
        vecs[3]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[4]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[5]  = '{4'b0110, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1};
        vecs[6]  = '{4'b0110, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1};
        vecs[7]  = '{4'b0100, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1};
        vecs[8]  = '{4'b0100, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1};
        vecs[9]  = '{4'b0100, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1};
        vecs[10] = '{4'b0100, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1};
        vecs[11] = '{4'b0100, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1};
        vecs[12] = '{4'b0100, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1};
        vecs[13] = '{4'b0100, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1};
        vecs[14] = '{4'b0100, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1};
        vecs[15] = '{4'b0100, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1};
        vecs[16] = '{4'b0100, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1};
        vecs[17] = '{4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0};
        // Up then down one cycle apart: back-to-back commands, no bubble.
        vecs[18] = '{4'b0001, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1};
        vecs[19] = '{4'b0011, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1};
        vecs[20] = '{4'b0011, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1};
        vecs[21] = '{4'b0000, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0};
        // Consumer stalled: up is buffered, left is dropped into overflow.
        vecs[22] = '{4'b0001, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1};
        vecs[23] = '{4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
        vecs[24] = '{4'b0100, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1};
        vecs[25] = '{4'b0100, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1};
        vecs[26] = '{4'b0000, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
        vecs[27] = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[28] = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset", 0, 1'b0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i].btn, vecs[i].ready);
            checkOutput("table", i, vecs[i].exp_valid, vecs[i].exp_dir,
                        vecs[i].exp_ovf, vecs[i].exp_held);
        end

        // Hold right for 28 cycles: press plus repeats at +8, then every 4.
        for (int k = 0; k < 40; k++) begin
            b  = (k < 28) ? 4'b1000 : 4'b0000;
            ev = (k == 1 || k == 9 || k == 13 || k == 17 || k == 21 || k == 25);
            ed = (k == 0) ? 2'd0 : 2'd3;
            applyStimulus(b, 1'b1);
            checkOutput("hold_right", k, ev, ed, 1'b1, (k < 28));
        end

        // Hold right, add up at cycle 5: immediate up, timer restarts.
        for (int k = 0; k < 18; k++) begin
            b  = (k < 5) ? 4'b1000 : ((k < 16) ? 4'b1001 : 4'b0000);
            ev = (k == 1 || k == 6 || k == 14);
            ed = (k < 6) ? 2'd3 : 2'd0;
            applyStimulus(b, 1'b1);
            checkOutput("repress", k, ev, ed, 1'b1, (k < 16));
        end

        // Hold left into REPEAT with a command pending, then reset mid-hold.
        for (int k = 0; k < 10; k++) begin
            ev = (k == 1 || k == 9);
            ed = (k == 0) ? 2'd0 : 2'd2;
            applyStimulus(4'b0100, 1'b1);
            checkOutput("pre_reset", k, ev, ed, 1'b1, 1'b1);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 0, 1'b0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        btn   = 4'b0000;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0000, 1'b1);
            checkOutput("post_reset_idle", k, 1'b0, 2'd0, 1'b0, 1'b0);
        end

        // Button already held when reset releases counts as one press.
        @(negedge clk);
        rst_n = 1'b0;
        btn   = 4'b0010;
        @(posedge clk);
        #1;
        checkOutput("reset_held_btn", 0, 1'b0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("held_after_reset", 0, 1'b0, 2'd0, 1'b0, 1'b1);
        applyStimulus(4'b0010, 1'b1);
        checkOutput("held_after_reset", 1, 1'b1, 2'd1, 1'b0, 1'b1);
        applyStimulus(4'b0010, 1'b1);
        checkOutput("held_after_reset", 2, 1'b0, 2'd1, 1'b0, 1'b1);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("held_after_reset", 3, 1'b0, 2'd1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
